// File: rtl/pci_pkg.sv
// Shared definitions for the PCI bus arbiter: FSM encoding, policy codes,
// bus-phase helper and the device address map used by the surrounding system.
package pci_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        OWNED = 2'd2,
        TURN  = 2'd3
    } arb_state_e;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    // Grant-to-FRAME timer width; TIMEOUT never exceeds 255.
    localparam int TIMER_W = 8;

    localparam logic [31:0] DEVICE_0_ADDRESS = 32'h0000_1000;
    localparam logic [31:0] DEVICE_1_ADDRESS = 32'h0000_2000;
    localparam logic [31:0] DEVICE_2_ADDRESS = 32'h0000_3000;
    localparam logic [31:0] DEVICE_3_ADDRESS = 32'h0000_4000;
    localparam logic [31:0] DEVICE_4_ADDRESS = 32'h0000_5000;

    // FRAME# and IRDY# both deasserted: no transaction is in flight.
    function automatic logic bus_idle(input logic frame, input logic irdy);
        return frame & irdy;
    endfunction

    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/pci_rr_picker.sv
// Combinational winner selection over active-low requests: a rotating search
// starting at ptr (round-robin) or at index 0 (fixed priority).
module pci_rr_picker #(
    parameter int  N_REQ = 5,
    localparam int IDXW  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_n,
    input  logic [IDXW-1:0]  ptr,
    input  logic             mode,
    output logic [IDXW-1:0]  winner,
    output logic             any
);

    localparam int SW = IDXW + 1;

    logic [IDXW-1:0]  base;
    logic [IDXW-1:0]  cand_idx [N_REQ];
    logic [N_REQ-1:0] cand_hit;

    // Fixed priority is simply a rotation that always starts at zero.
    assign base = mode ? ptr : '0;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
        logic [SW-1:0] sum;
        assign sum          = {1'b0, base} + SW'(gi);
        assign cand_idx[gi] = (sum >= SW'(N_REQ)) ? IDXW'(sum - SW'(N_REQ)) : sum[IDXW-1:0];
        assign cand_hit[gi] = ~req_n[cand_idx[gi]];
    end

    always_comb begin
        winner = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (cand_hit[k]) begin
                winner = cand_idx[k];
            end
        end
    end

    assign any = |cand_hit;

endmodule

// File: rtl/pci_bus_arbiter.sv
// Central PCI bus arbiter: one-cold active-low grants with fixed or round-robin
// policy, bus parking, grant-to-FRAME timeout and a turnaround cycle between owners.
module pci_bus_arbiter
    import pci_pkg::*;
#(
    parameter int  N_REQ    = 5,
    parameter int  MODE     = 1,
    parameter int  PARK_EN  = 1,
    parameter int  PARK_IDX = 0,
    parameter int  TIMEOUT  = 16,
    localparam int IDXW     = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             RST,
    input  logic [N_REQ-1:0] REQ,
    input  logic             FRAME,
    input  logic             IRDY,
    output logic [N_REQ-1:0] GNT,
    output logic [IDXW-1:0]  OWNER,
    output logic             OWNER_VLD,
    output logic             TMO_ERR
);

    localparam logic [N_REQ-1:0]   ALL_HIGH   = '1;
    localparam logic [IDXW-1:0]    PARK_OWNER = IDXW'(PARK_IDX);
    localparam logic [TIMER_W-1:0] TMO_LAST   = TIMER_W'(TIMEOUT - 1);

    function automatic logic [N_REQ-1:0] grant_vec(input logic [IDXW-1:0] idx);
        return ~(N_REQ'(1) << idx);
    endfunction

    arb_state_e         state_reg;
    logic [N_REQ-1:0]   gnt_reg;
    logic [IDXW-1:0]    owner_reg;
    logic               owner_vld_reg;
    logic               tmo_err_reg;
    logic [IDXW-1:0]    rr_ptr_reg;
    logic [TIMER_W-1:0] timer_reg;

    logic [IDXW-1:0]    pick_winner;
    logic               pick_any;
    logic [IDXW-1:0]    owner_inc;

    arb_state_e         arb_state_next;
    logic [N_REQ-1:0]   arb_gnt_next;
    logic [IDXW-1:0]    arb_owner_next;
    logic               arb_vld_next;

    pci_rr_picker #(
        .N_REQ (N_REQ)
    ) u_picker (
        .req_n  (REQ),
        .ptr    (rr_ptr_reg),
        .mode   (MODE == MODE_RR),
        .winner (pick_winner),
        .any    (pick_any)
    );

    assign owner_inc = IDXW'(wrap_inc(int'(owner_reg), N_REQ));

    // Outcome of an arbitration pass; TURN applies it directly on exit so the
    // bus sees exactly one all-high grant cycle between owners.
    always_comb begin
        arb_state_next = IDLE;
        arb_gnt_next   = ALL_HIGH;
        arb_owner_next = owner_reg;
        arb_vld_next   = 1'b0;
        if (pick_any) begin
            arb_state_next = GRANT;
            arb_gnt_next   = grant_vec(pick_winner);
            arb_owner_next = pick_winner;
            arb_vld_next   = 1'b1;
        end else if (PARK_EN != 0) begin
            arb_gnt_next   = grant_vec(PARK_OWNER);
            arb_owner_next = PARK_OWNER;
            arb_vld_next   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!RST) begin
            state_reg     <= IDLE;
            gnt_reg       <= ALL_HIGH;
            owner_reg     <= PARK_OWNER;
            owner_vld_reg <= 1'b0;
            tmo_err_reg   <= 1'b0;
            rr_ptr_reg    <= '0;
            timer_reg     <= '0;
        end else begin
            tmo_err_reg <= 1'b0;
            unique case (state_reg)
                IDLE: begin
                    // A parked master may start without requesting.
                    if (owner_vld_reg && !FRAME) begin
                        state_reg <= OWNED;
                    end else begin
                        state_reg     <= arb_state_next;
                        gnt_reg       <= arb_gnt_next;
                        owner_reg     <= arb_owner_next;
                        owner_vld_reg <= arb_vld_next;
                        timer_reg     <= '0;
                    end
                end
                GRANT: begin
                    if (!FRAME) begin
                        state_reg <= OWNED;
                        if (MODE == MODE_RR) begin
                            rr_ptr_reg <= owner_inc;
                        end
                    end else if (REQ[owner_reg]) begin
                        state_reg     <= TURN;
                        gnt_reg       <= ALL_HIGH;
                        owner_vld_reg <= 1'b0;
                    end else if (timer_reg == TMO_LAST) begin
                        state_reg     <= TURN;
                        gnt_reg       <= ALL_HIGH;
                        owner_vld_reg <= 1'b0;
                        tmo_err_reg   <= 1'b1;
                        rr_ptr_reg    <= owner_inc;
                    end else if (timer_reg != '1) begin
                        timer_reg <= timer_reg + TIMER_W'(1);
                    end
                end
                OWNED: begin
                    if (bus_idle(FRAME, IRDY)) begin
                        state_reg     <= TURN;
                        gnt_reg       <= ALL_HIGH;
                        owner_vld_reg <= 1'b0;
                    end
                end
                TURN: begin
                    state_reg     <= arb_state_next;
                    gnt_reg       <= arb_gnt_next;
                    owner_reg     <= arb_owner_next;
                    owner_vld_reg <= arb_vld_next;
                    timer_reg     <= '0;
                end
            endcase
        end
    end

    assign GNT       = gnt_reg;
    assign OWNER     = owner_reg;
    assign OWNER_VLD = owner_vld_reg;
    assign TMO_ERR   = tmo_err_reg;

endmodule

// File: tb/tb_pci_bus_arbiter.sv
// Scoreboard bench: dut_a is round-robin, dut_b fixed priority; stimulus pushes
// expected grant changes and timeout pulses, a negedge monitor pops and compares.
module tb_pci_bus_arbiter;

    localparam int N = 5;

    typedef struct {
        logic [N-1:0] gnt;
        int           owner;
        int           cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_in   [2];
    logic [N-1:0] req_in   [2];
    logic         frame_in [2];
    logic         irdy_in  [2];

    logic [N-1:0] gnt_a, gnt_b;
    logic [2:0]   owner_a, owner_b;
    logic         vld_a, vld_b, tmo_a, tmo_b;

    logic [N-1:0] gnt_w   [2];
    logic [2:0]   owner_w [2];
    logic         vld_w   [2];
    logic         tmo_w   [2];

    exp_t gq0[$], gq1[$];
    int   tq0[$], tq1[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic         rst_seen [2];
    logic [N-1:0] prev_gnt [2] = '{5'b11111, 5'b11111};
    int   rr_order [6] = '{0, 1, 2, 3, 4, 0};

    always #5 clk = ~clk;

    pci_bus_arbiter #(.N_REQ(5), .MODE(1), .PARK_EN(1), .PARK_IDX(0), .TIMEOUT(16)) dut_a (
        .clk(clk), .RST(rst_in[0]), .REQ(req_in[0]), .FRAME(frame_in[0]), .IRDY(irdy_in[0]),
        .GNT(gnt_a), .OWNER(owner_a), .OWNER_VLD(vld_a), .TMO_ERR(tmo_a)
    );

    pci_bus_arbiter #(.N_REQ(5), .MODE(0), .PARK_EN(1), .PARK_IDX(0), .TIMEOUT(16)) dut_b (
        .clk(clk), .RST(rst_in[1]), .REQ(req_in[1]), .FRAME(frame_in[1]), .IRDY(irdy_in[1]),
        .GNT(gnt_b), .OWNER(owner_b), .OWNER_VLD(vld_b), .TMO_ERR(tmo_b)
    );

    assign gnt_w[0] = gnt_a;   assign gnt_w[1] = gnt_b;
    assign owner_w[0] = owner_a; assign owner_w[1] = owner_b;
    assign vld_w[0] = vld_a;   assign vld_w[1] = vld_b;
    assign tmo_w[0] = tmo_a;   assign tmo_w[1] = tmo_b;

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        rst_seen[0] <= rst_in[0];
        rst_seen[1] <= rst_in[1];
    end

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h at cyc %0d", name, act, exp, cyc);
        end
    endtask

    task automatic monitor_dut(input int d);
        exp_t         e;
        int           t;
        int           qn;
        logic [N-1:0] g;
        g = gnt_w[d];
        check($countones(~g) <= 1, "gnt_one_cold", 32'(g), 32'(5'b11111));
        check(vld_w[d] === (g != 5'b11111), "owner_vld_tracks_gnt", 32'(vld_w[d]), 32'(g != 5'b11111));
        if (rst_seen[d] === 1'b0) begin
            check(g === 5'b11111 && vld_w[d] === 1'b0 && tmo_w[d] === 1'b0 && owner_w[d] === 3'd0,
                  "reset_state", 32'({g, vld_w[d], tmo_w[d], owner_w[d]}), 32'({5'b11111, 1'b0, 1'b0, 3'd0}));
        end
        if (g !== prev_gnt[d]) begin
            $display("dut%0d cyc %0d gnt %b owner %0d vld %b", d, cyc, g, owner_w[d], vld_w[d]);
            qn = (d == 0) ? gq0.size() : gq1.size();
            check(qn != 0, "gnt_change_expected", 32'(g), 32'(prev_gnt[d]));
            if (qn != 0) begin
                if (d == 0) e = gq0.pop_front();
                else        e = gq1.pop_front();
                check(g === e.gnt, "gnt_value", 32'(g), 32'(e.gnt));
                check(owner_w[d] === 3'(e.owner), "owner", 32'(owner_w[d]), 32'(e.owner));
                check(cyc == e.cyc, "gnt_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
        if (tmo_w[d] === 1'b1) begin
            $display("dut%0d cyc %0d tmo_err pulse owner %0d", d, cyc, owner_w[d]);
            qn = (d == 0) ? tq0.size() : tq1.size();
            check(qn != 0, "tmo_expected", 32'(cyc), 32'(0));
            if (qn != 0) begin
                if (d == 0) t = tq0.pop_front();
                else        t = tq1.pop_front();
                check(cyc == t, "tmo_cycle", 32'(cyc), 32'(t));
            end
        end
        prev_gnt[d] = g;
    endtask

    always @(negedge clk) begin
        if (cyc >= 1) begin
            monitor_dut(0);
            monitor_dut(1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_gnt(input int d, input logic [N-1:0] g, input int o, input int at);
        exp_t e;
        e.gnt = g;
        e.owner = o;
        e.cyc = at;
        if (d == 0) gq0.push_back(e);
        else        gq1.push_back(e);
    endtask

    function automatic logic [N-1:0] cold(input int i);
        logic [N-1:0] one;
        one = 5'b00001;
        return ~(one << i);
    endfunction

    // Address phase, two data phases, then idle; grant released 4 clocks later.
    task automatic run_txn(input int d, input int o);
        expect_gnt(d, 5'b11111, o, cyc + 4);
        frame_in[d] = 1'b0; irdy_in[d] = 1'b1; tick();
        frame_in[d] = 1'b0; irdy_in[d] = 1'b0; tick();
        frame_in[d] = 1'b1; irdy_in[d] = 1'b0; tick();
        frame_in[d] = 1'b1; irdy_in[d] = 1'b1; tick();
    endtask

    initial begin
        rst_in[0] = 1'b0; rst_in[1] = 1'b0;
        req_in[0] = 5'b00000; req_in[1] = 5'b11111;
        frame_in[0] = 1'b1; frame_in[1] = 1'b1;
        irdy_in[0] = 1'b1; irdy_in[1] = 1'b1;

        // Reset held 3 clocks, then channel 0 (a) / park (b) one clock later
        repeat (3) tick();
        rst_in[0] = 1'b1; rst_in[1] = 1'b1;
        expect_gnt(0, 5'b11110, 0, cyc + 1);
        expect_gnt(1, 5'b11110, 0, cyc + 1);
        tick();

        // Round-robin fairness with all requests held low
        for (int k = 0; k < 5; k++) begin
            run_txn(0, rr_order[k]);
            expect_gnt(0, cold(rr_order[k + 1]), rr_order[k + 1], cyc + 1);
            tick();
        end
        req_in[0] = 5'b11111;
        expect_gnt(0, 5'b11111, 0, cyc + 1);
        expect_gnt(0, 5'b11110, 0, cyc + 2);
        tick(); tick();

        // Parking: idle for 10 clocks, then parked master runs a transaction
        repeat (10) tick();
        run_txn(0, 0);
        expect_gnt(0, 5'b11110, 0, cyc + 1);
        tick();

        // Timeout on channel 2 with channel 3 also requesting
        req_in[0] = 5'b10011;
        expect_gnt(0, 5'b11011, 2, cyc + 1);
        expect_gnt(0, 5'b11111, 2, cyc + 17);
        tq0.push_back(cyc + 17);
        expect_gnt(0, 5'b10111, 3, cyc + 18);
        repeat (18) tick();
        req_in[0] = 5'b11111;
        expect_gnt(0, 5'b11111, 3, cyc + 1);
        expect_gnt(0, 5'b11110, 0, cyc + 2);
        tick(); tick();

        // Reset while the parked master owns the bus
        frame_in[0] = 1'b0; irdy_in[0] = 1'b1; tick();
        frame_in[0] = 1'b0; irdy_in[0] = 1'b0; rst_in[0] = 1'b0;
        expect_gnt(0, 5'b11111, 0, cyc + 1);
        tick();
        rst_in[0] = 1'b1; frame_in[0] = 1'b1; irdy_in[0] = 1'b1;
        req_in[0] = 5'b01111;
        expect_gnt(0, 5'b01111, 4, cyc + 1);
        tick();
        req_in[0] = 5'b11111;
        expect_gnt(0, 5'b11111, 4, cyc + 1);
        expect_gnt(0, 5'b11110, 0, cyc + 2);
        tick(); tick();

        // Fixed priority: channels 1 and 3 together
        req_in[1] = 5'b10101;
        expect_gnt(1, 5'b11101, 1, cyc + 1);
        tick();
        req_in[1] = 5'b10111;
        run_txn(1, 1);
        expect_gnt(1, 5'b10111, 3, cyc + 1);
        tick();
        req_in[1] = 5'b11111;
        run_txn(1, 3);
        expect_gnt(1, 5'b11110, 0, cyc + 1);
        tick();

        // Fixed priority ignores rotation history: 1 beats 4
        req_in[1] = 5'b01101;
        expect_gnt(1, 5'b11101, 1, cyc + 1);
        tick();
        req_in[1] = 5'b11111;
        expect_gnt(1, 5'b11111, 1, cyc + 1);
        expect_gnt(1, 5'b11110, 0, cyc + 2);
        tick(); tick();

        repeat (3) tick();
        check(gq0.size() == 0, "pending_gnt_dut0", 32'(gq0.size()), 32'(0));
        check(gq1.size() == 0, "pending_gnt_dut1", 32'(gq1.size()), 32'(0));
        check(tq0.size() == 0, "pending_tmo_dut0", 32'(tq0.size()), 32'(0));
        check(tq1.size() == 0, "pending_tmo_dut1", 32'(tq1.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit at cyc %0d", cyc);
        $fatal(1);
    end

endmodule
